divider: RTL and testbench
==========================

// Module: divider
// PURPOSE
//   Iterative radix-2 restoring divider for the execute stage; the companion of the
//   multiplier on the HI/LO path (DIV/DIVU). Computes quotient and remainder of a / b
//   over WIDTH+2 cycles, one quotient bit per cycle. Uses the same valid/done stall
//   handshake as the multiplier, so execute stalls while (valid && !done).
// PARAMETERS
//   WIDTH  32  operand width; c is 2*WIDTH bits; iteration count = WIDTH
// PORTS
//   clk        in   1        clock, all state updates on posedge
//   reset      in   1        synchronous, active-high; clears all state
//   valid      in   1        request; held high by execute until done
//   is_signed  in   1        1 = DIV (two's complement), 0 = DIVU; sampled with a, b
//   a          in   WIDTH    dividend
//   b          in   WIDTH    divisor
//   done       out  1        result ready / no stall needed (see BEHAVIOUR)
//   c          out  2*WIDTH  {remainder, quotient}: c[63:32] -> HI, c[31:0] -> LO
// BEHAVIOUR
//   - Reset: state=IDLE, counter=0, all datapath regs 0; c=0; done=~valid (IDLE rule).
//   - FSM IDLE -> BUSY -> FINISH -> IDLE.
//     IDLE:   valid=1 -> latch |a|,|b| (abs only if is_signed), sign_q=a[31]^b[31],
//             sign_r=a[31] (both 0 if unsigned), rem=0, cnt=0 -> BUSY. valid=0 -> stay.
//     BUSY:   per cycle: {rem,quo} <<= 1 shifted with dividend MSB; if rem >= |b| then
//             rem -= |b|, quo[0]=1. cnt++; after the WIDTH-th step (cnt==WIDTH-1) -> FINISH.
//     FINISH: c registered with sign fixup (quo negated if sign_q, rem negated if
//             sign_r); done=1 for exactly this cycle; -> IDLE unconditionally.
//   - done = (state==IDLE && !valid) || state==FINISH; combinational from state/valid.
//   - Latency: valid rises in cycle 0 (IDLE) -> done=1 in cycle WIDTH+1 (33 for 32).
//   - c holds its last result in IDLE/BUSY until the next FINISH overwrites it.
//   - valid and inputs are sampled only in IDLE; changes during BUSY/FINISH are ignored.
//     valid still high in the IDLE after FINISH is treated as a new request.
//   - Signed rules: remainder takes the sign of the dividend; quotient truncates
//     toward zero. -2^31 / -1 -> quo=32'h8000_0000, rem=0 (no trap).
//   - Divide by zero: no special case; the datapath naturally yields quo=all ones,
//     rem=|a|, then sign fixup applies. DIVU x/0 -> {a, 32'hFFFF_FFFF}.
//     Latency identical to the normal case; no early termination for any operand.
//   - reset mid-BUSY/FINISH: back to IDLE next edge, partial result discarded, c=0.
//   - Abs/negate use WIDTH-bit two's complement; |−2^31| = 32'h8000_0000 as unsigned.
// STRUCTURE
//   - Shared package: divider state enum {IDLE, BUSY, FINISH} and DIV_CNT_W =
//     $clog2(WIDTH); i32/i64 from the existing interface types.
//   - Sub-module div_step: combinational single restoring iteration
//     (rem, quo, divisor) -> (rem', quo'); instantiated once, driven by BUSY regs.
//   - Top: FSM, counter, operand/sign latch, fixup registers.
// TESTING
//   1 DIVU a=100 b=7 -> done at cycle 33 exactly, c={32'd2, 32'd14}; done=0 cycles 0-32.
//   2 DIV a=-7 (32'hFFFF_FFF9) b=2 -> quo=32'hFFFF_FFFD (-3), rem=32'hFFFF_FFFF (-1).
//   3 DIV a=32'h8000_0000 b=32'hFFFF_FFFF -> c={32'h0, 32'h8000_0000}.
//   4 DIVU a=32'h1234_5678 b=0 -> c={32'h1234_5678, 32'hFFFF_FFFF}, latency 33.
//   5 Back-to-back: valid held through FINISH with new a=9 b=3 -> second op starts in
//     following IDLE, c={0,3} 34 cycles after first done; first result not corrupted.
//   6 reset=1 at cycle 10 of a DIV -> next cycle IDLE, c=0, done=~valid; new op OK.

Source files
------------

// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
// Module   : divider_pkg
// Purpose  : Shared types and constants for the iterative restoring divider.
// Revision : 1.0 - initial release
// ============================================================================
package divider_pkg;

   // Default operand width and the iteration counter width that goes with it
   localparam int DIV_WIDTH = 32;
   localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

   // Execute-stage interface word types
   typedef logic [31:0] i32;
   typedef logic [63:0] i64;

   // Divider sequencing states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY   = 2'd1,
      FINISH = 2'd2
   } div_state_e;

endpackage
`default_nettype wire

// File: rtl/divider_div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Purpose  : One combinational restoring-division iteration. Shifts the
//            {rem, quo} pair left by one, trial-subtracts the divisor and
//            keeps the difference when it is non-negative.
// Revision : 1.0 - initial release
// ============================================================================
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_quo,
   input  logic [WIDTH-1:0] i_dvs,
   output logic [WIDTH-1:0] o_rem,
   output logic [WIDTH-1:0] o_quo
);

   logic [WIDTH:0] w_trial;
   logic [WIDTH:0] w_diff;
   logic           w_ge;

   // Trial subtraction one bit wider than the operands. The partial remainder
   // is always below the divisor, so the shifted trial is below twice the
   // divisor; the difference is then either in [0, divisor) or negative, and
   // its top bit alone tells which.
   always_comb begin
      w_trial = {i_rem, i_quo[WIDTH-1]};
      w_diff  = w_trial - {1'b0, i_dvs};
      w_ge    = ~w_diff[WIDTH];
      o_rem   = w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
      o_quo   = {i_quo[WIDTH-2:0], w_ge};
   end

endmodule
`default_nettype wire

// File: rtl/divider.sv
`default_nettype none
// ============================================================================
// Module   : divider
// Purpose  : Iterative radix-2 restoring divider (DIV/DIVU) for the HI/LO
//            path. One quotient bit per cycle; result {rem, quo} on c with a
//            valid/done stall handshake shared with the multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module divider
   import divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 valid,
   input  logic                 is_signed,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   c
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   div_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   logic               neg_quo_q, neg_quo_d;
   logic               neg_rem_q, neg_rem_d;
   logic [2*WIDTH-1:0] c_q, c_d;

   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic [WIDTH-1:0]   w_rem_nxt;
   logic [WIDTH-1:0]   w_quo_nxt;
   logic [WIDTH-1:0]   w_rem_fix;
   logic [WIDTH-1:0]   w_quo_fix;

   // Single iteration datapath, fed directly from the working registers
   div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_rem (rem_q),
      .i_quo (quo_q),
      .i_dvs (dvs_q),
      .o_rem (w_rem_nxt),
      .o_quo (w_quo_nxt)
   );

   // Operand magnitudes and final sign fixup; -2^(W-1) maps onto itself,
   // which is the correct unsigned magnitude
   always_comb begin
      w_abs_a   = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
      w_abs_b   = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
      w_quo_fix = neg_quo_q ? (~w_quo_nxt + WIDTH'(1)) : w_quo_nxt;
      w_rem_fix = neg_rem_q ? (~w_rem_nxt + WIDTH'(1)) : w_rem_nxt;
   end

   // Next-state logic: latch operands in IDLE, iterate in BUSY, and capture
   // the fixed-up result on the last iteration so it is on c during FINISH
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      c_d       = c_q;
      case (state_q)
         IDLE: begin
            if (valid) begin
               quo_d     = w_abs_a;
               dvs_d     = w_abs_b;
               rem_d     = '0;
               cnt_d     = '0;
               neg_quo_d = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
               neg_rem_d = is_signed & a[WIDTH-1];
               state_d   = BUSY;
            end
         end
         BUSY: begin
            rem_d = w_rem_nxt;
            quo_d = w_quo_nxt;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               c_d     = {w_rem_fix, w_quo_fix};
               state_d = FINISH;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         c_q       <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         c_q       <= c_d;
      end
   end

   // No stall when idle with no request, or in the single result cycle
   always_comb begin
      done = ((state_q == IDLE) && !valid) || (state_q == FINISH);
      c    = c_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_divider
// Purpose  : Self-checking bench for divider: scoreboard of expected
//            {rem, quo} results from an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_divider;

   logic        clk;
   logic        reset;
   logic        valid;
   logic        is_signed;
   logic [31:0] a;
   logic [31:0] b;
   logic        done;
   logic [63:0] c;

   int          checks;
   int          errors;
   logic [63:0] sb_q[$];

   divider #(
      .WIDTH (32)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .valid     (valid),
      .is_signed (is_signed),
      .a         (a),
      .b         (b),
      .done      (done),
      .c         (c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference result using native integer division
   function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                         input logic s);
      longint      sx;
      longint      sy;
      logic [31:0] q;
      logic [31:0] r;
      if (!s) begin
         if (y == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = x;
         end else begin
            q = x / y;
            r = x % y;
         end
      end else begin
         sx = longint'($signed(x));
         sy = longint'($signed(y));
         if (sy == 0) begin
            q = (sx < 0) ? 32'd1 : 32'hFFFF_FFFF;
            r = x;
         end else begin
            q = 32'(sx / sy);
            r = 32'(sx % sy);
         end
      end
      return {r, q};
   endfunction

   function automatic logic [63:0] sb_pop();
      if (sb_q.size() == 0) return 64'hx;
      return sb_q.pop_front();
   endfunction

   // Present a request in the current cycle and record its expected result
   task automatic drive_op(input logic [31:0] op_a, input logic [31:0] op_b, input logic op_s);
      a         = op_a;
      b         = op_b;
      is_signed = op_s;
      valid     = 1'b1;
      sb_q.push_back(model(op_a, op_b, op_s));
      #1;
   endtask

   task automatic start_op(input logic [31:0] op_a, input logic [31:0] op_b, input logic op_s);
      @(negedge clk);
      drive_op(op_a, op_b, op_s);
   endtask

   // Count cycles until done, bounded
   task automatic wait_done(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         #1;
         cyc++;
      end while (!done && cyc < 100);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      valid = 1'b0;
      a = '0; b = '0; is_signed = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (c !== 64'd0) begin
         errors++; $display("FAIL reset_c: got %h want %h", c, 64'd0);
      end
      checks++;
      if (done !== 1'b1) begin
         errors++; $display("FAIL reset_done_idle: got %b want 1", done);
      end
      valid = 1'b1;
      #1;
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL reset_done_valid: got %b want 0", done);
      end
      valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
   endtask

   task automatic test_divu_basic();
      int          cyc;
      logic [63:0] exp;
      start_op(32'd100, 32'd7, 1'b0);
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL divu_cycle0_done: got %b want 0", done);
      end
      wait_done(cyc);
      exp = sb_pop();
      checks++;
      if (cyc != 33 || done !== 1'b1) begin
         errors++; $display("FAIL divu_latency: got %0d want 33", cyc);
      end
      checks++;
      if (c !== {32'd2, 32'd14} || c !== exp) begin
         errors++; $display("FAIL divu_result: got %h want %h", c, exp);
      end
      valid = 1'b0;
   endtask

   task automatic test_signed();
      int          cyc;
      logic [63:0] exp;
      start_op(32'hFFFF_FFF9, 32'd2, 1'b1);
      wait_done(cyc);
      exp = sb_pop();
      checks++;
      if (c !== {32'hFFFF_FFFF, 32'hFFFF_FFFD} || c !== exp) begin
         errors++; $display("FAIL div_neg7_by_2: got %h want %h", c, exp);
      end
      valid = 1'b0;
      start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      wait_done(cyc);
      exp = sb_pop();
      checks++;
      if (c !== {32'h0, 32'h8000_0000} || c !== exp) begin
         errors++; $display("FAIL div_overflow: got %h want %h", c, exp);
      end
      valid = 1'b0;
      start_op(32'd45, 32'hFFFF_FFFA, 1'b1);
      wait_done(cyc);
      exp = sb_pop();
      checks++;
      if (c !== exp) begin
         errors++; $display("FAIL div_pos_by_neg: got %h want %h", c, exp);
      end
      valid = 1'b0;
   endtask

   task automatic test_div_zero();
      int          cyc;
      logic [63:0] exp;
      start_op(32'h1234_5678, 32'd0, 1'b0);
      wait_done(cyc);
      exp = sb_pop();
      checks++;
      if (cyc != 33) begin
         errors++; $display("FAIL divu_zero_latency: got %0d want 33", cyc);
      end
      checks++;
      if (c !== {32'h1234_5678, 32'hFFFF_FFFF} || c !== exp) begin
         errors++; $display("FAIL divu_zero_result: got %h want %h", c, exp);
      end
      valid = 1'b0;
      start_op(32'hFFFF_FFFB, 32'd0, 1'b1);
      wait_done(cyc);
      exp = sb_pop();
      checks++;
      if (c !== exp) begin
         errors++; $display("FAIL div_zero_signed: got %h want %h", c, exp);
      end
      valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      int          cyc;
      logic [63:0] exp;
      start_op(32'd1000, 32'd10, 1'b0);
      wait_done(cyc);
      exp = sb_pop();
      checks++;
      if (c !== {32'd0, 32'd100} || c !== exp) begin
         errors++; $display("FAIL b2b_first: got %h want %h", c, exp);
      end
      // valid stays high through FINISH with the next operands
      drive_op(32'd9, 32'd3, 1'b0);
      wait_done(cyc);
      exp = sb_pop();
      checks++;
      if (cyc != 34) begin
         errors++; $display("FAIL b2b_latency: got %0d want 34", cyc);
      end
      checks++;
      if (c !== {32'd0, 32'd3} || c !== exp) begin
         errors++; $display("FAIL b2b_second: got %h want %h", c, exp);
      end
      valid = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      checks++;
      if (c !== {32'd0, 32'd3} || done !== 1'b1) begin
         errors++; $display("FAIL hold_idle: got c=%h done=%b want c=%h done=1", c, done, {32'd0, 32'd3});
      end
   endtask

   task automatic test_ignore_busy_inputs();
      int          cyc;
      logic [63:0] exp;
      start_op(32'd50, 32'd5, 1'b0);
      repeat (3) @(negedge clk);
      a = 32'hFFFF_0000; b = 32'd1; is_signed = 1'b1;
      #1;
      wait_done(cyc);
      exp = sb_pop();
      checks++;
      if (c !== {32'd0, 32'd10} || c !== exp) begin
         errors++; $display("FAIL busy_inputs_ignored: got %h want %h", c, exp);
      end
      valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      int          cyc;
      logic [63:0] exp;
      start_op(32'hFFFF_FF9C, 32'd7, 1'b1);
      repeat (10) @(negedge clk);
      reset = 1'b1;
      valid = 1'b0;
      exp = sb_pop();
      @(negedge clk);
      #1;
      checks++;
      if (c !== 64'd0 || done !== 1'b1) begin
         errors++; $display("FAIL reset_mid: got c=%h done=%b want c=0 done=1", c, done);
      end
      reset = 1'b0;
      start_op(32'hFFFF_FF9C, 32'd7, 1'b1);
      wait_done(cyc);
      exp = sb_pop();
      checks++;
      if (cyc != 33 || c !== {32'hFFFF_FFFE, 32'hFFFF_FFF2} || c !== exp) begin
         errors++; $display("FAIL after_reset_op: got c=%h cyc=%0d want c=%h cyc=33", c, cyc, exp);
      end
      valid = 1'b0;
   endtask

   task automatic test_random();
      int          cyc;
      logic [63:0] exp;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rs;
      for (int i = 0; i < 10; i++) begin
         ra = $urandom;
         rb = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
         if (i % 3 == 0) rb = -rb;
         rs = i[0] ^ i[1];
         start_op(ra, rb, rs);
         wait_done(cyc);
         exp = sb_pop();
         checks++;
         if (cyc != 33 || c !== exp) begin
            errors++; $display("FAIL random_%0d: got c=%h cyc=%0d want c=%h cyc=33", i, c, cyc, exp);
         end
         valid = 1'b0;
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_divu_basic();
      test_signed();
      test_div_zero();
      test_back_to_back();
      test_ignore_busy_inputs();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
